// File: rtl/coef_burst_pkg.sv
// Shared types and helpers for the coefficient burst streamer.
package coef_burst_pkg;

  localparam int unsigned IDX_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Coefficient word layout: {bank[1:0], idx[5:0]}
  function automatic logic [7:0] coef_word(input logic [1:0]       bank,
                                           input logic [IDX_W-1:0] idx);
    return {bank, idx};
  endfunction

endpackage

// File: rtl/coef_fifo.sv
// Synchronous FIFO with full/empty/count status. Push while full is accepted
// only when a pop happens in the same cycle. Output reads zero while empty.
module coef_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since reads are gated by empty
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coef_burst_stream.sv
// Streams BURST_LEN coefficient words per bank-address change through an
// output FIFO. Optional feature macro: COEF_BURST_PARITY_EN adds out_parity
// (even parity over {out_last, out_data}) stored alongside each FIFO entry.
module coef_burst_stream
  import coef_burst_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned NUM_BANKS  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [5:0] addr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
`ifdef COEF_BURST_PARITY_EN
  output logic       out_parity,
`endif
  output logic       overrun,
  output logic       bad_addr
);

`ifdef COEF_BURST_PARITY_EN
  localparam int unsigned FW = 10;
`else
  localparam int unsigned FW = 9;
`endif
  localparam int unsigned        CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_t           state;
  logic [5:0]       addr_q;
  logic             first;
  logic [1:0]       bank;
  logic [IDX_W-1:0] idx;
  logic             pend;
  logic [1:0]       pend_addr;

  logic             change;
  logic             addr_legal;
  logic             change_ok;
  logic             pop;
  logic             push_ok;
  logic             is_last;
  logic [7:0]       word;
  logic [FW-1:0]    fifo_din;
  logic [FW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    unused_fifo_count;

  assign change     = (addr != addr_q) | first;
  assign addr_legal = (32'(addr) < NUM_BANKS);
  assign change_ok  = change & addr_legal;
  assign pop        = out_valid & out_ready;
  assign push_ok    = (state == BURST) & (~fifo_full | pop);
  assign is_last    = (idx == LAST_IDX);
  assign word       = coef_word(bank, idx);

`ifdef COEF_BURST_PARITY_EN
  assign fifo_din = {^{is_last, word}, is_last, word};
  assign {out_parity, out_last, out_data} = fifo_dout;
`else
  assign fifo_din = {is_last, word};
  assign {out_last, out_data} = fifo_dout;
`endif

  assign out_valid = ~fifo_empty;

  // Change detector: previous address and first-cycle-after-reset marker
  always_ff @(posedge CLK) begin
    addr_q <= addr;
    first  <= rst;
  end

  // Burst FSM with pending-change register, overrun pulse and sticky bad_addr.
  // A change arriving on the last push is folded into the next-burst decision
  // so it is neither lost nor reported as an overrun.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      bank      <= '0;
      idx       <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      overrun   <= 1'b0;
      bad_addr  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (change & ~addr_legal) bad_addr <= 1'b1;
      case (state)
        IDLE: begin
          if (change_ok) begin
            state <= BURST;
            bank  <= addr[1:0];
            idx   <= '0;
          end
        end
        BURST: begin
          if (push_ok & is_last) begin
            if (pend) begin
              bank <= pend_addr;
              idx  <= '0;
              pend <= change_ok;
              if (change_ok) pend_addr <= addr[1:0];
            end else if (change_ok) begin
              bank <= addr[1:0];
              idx  <= '0;
            end else begin
              state <= IDLE;
              idx   <= '0;
            end
          end else begin
            if (push_ok) idx <= idx + 1'b1;
            if (change_ok) begin
              pend      <= 1'b1;
              pend_addr <= addr[1:0];
              overrun   <= pend;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  coef_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

endmodule

// File: tb/tb_coef_burst_stream.sv
// Directed self-checking bench for coef_burst_stream (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_coef_burst_stream;

  logic       CLK = 1'b0;
  logic       rst;
  logic [5:0] addr;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       overrun;
  logic       bad_addr;
`ifdef COEF_BURST_PARITY_EN
  logic       out_parity;
`endif

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  coef_burst_stream #(
    .BURST_LEN  (16),
    .NUM_BANKS  (3),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .addr       (addr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
`ifdef COEF_BURST_PARITY_EN
    .out_parity (out_parity),
`endif
    .overrun    (overrun),
    .bad_addr   (bad_addr)
  );

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expects word 0 of the bank visible now; one word per cycle with out_ready=1
  task automatic check_burst(input string tag, input logic [1:0] bank);
    for (int i = 0; i < 16; i++) begin
      chk(tag, {5'd0, out_valid, out_last, out_data},
          {5'd0, 1'b1, (i == 15), bank, 6'(i)});
`ifdef COEF_BURST_PARITY_EN
      chk({tag, "_par"}, {15'd0, out_parity}, {15'd0, ^{(i == 15), bank, 6'(i)}});
`endif
      cyc();
    end
  endtask

  initial begin
    rst       = 1'b1;
    addr      = 6'd0;
    out_ready = 1'b1;
    cyc();
    cyc();
    // Reset state
    chk("rst_valid",   {15'd0, out_valid}, 16'd0);
    chk("rst_data",    {8'd0, out_data},   16'd0);
    chk("rst_last",    {15'd0, out_last},  16'd0);
    chk("rst_overrun", {15'd0, overrun},   16'd0);
    chk("rst_bad",     {15'd0, bad_addr},  16'd0);

    // Release: first cycle counts as a change on addr 0, two-cycle latency
    rst = 1'b0;
    cyc();
    chk("lat_b0_n1", {15'd0, out_valid}, 16'd0);
    cyc();
    check_burst("burst_b0", 2'd0);
    chk("b0_end_valid", {15'd0, out_valid}, 16'd0);
    cyc();
    cyc();

    // Idle change 0 -> 1
    addr = 6'd1;
    cyc();
    chk("lat_b1_n1", {15'd0, out_valid}, 16'd0);
    cyc();
    check_burst("burst_b1", 2'd1);
    chk("b1_end_valid", {15'd0, out_valid}, 16'd0);
    cyc();

    // Bank 2 with 10 stalled cycles: FIFO fills, head holds 0x80
    addr      = 6'd2;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 3) chk("stall_hold_mid", {7'd0, out_valid, out_data}, {7'd0, 1'b1, 8'h80});
    end
    chk("stall_count", 16'(dut.u_fifo.count), 16'd4);
    chk("stall_head",  {7'd0, out_valid, out_data}, {7'd0, 1'b1, 8'h80});
    chk("stall_last",  {15'd0, out_last}, 16'd0);
    out_ready = 1'b1;
    check_burst("burst_b2_resume", 2'd2);
    chk("b2_end_valid", {15'd0, out_valid}, 16'd0);
    cyc();

    // Bank 0 burst with changes to 1 then 2: one overrun, bank 2 follows
    addr = 6'd0;
    cyc();
    chk("lat_b0b_n1", {15'd0, out_valid}, 16'd0);
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("pend_b0", {5'd0, out_valid, out_last, out_data},
          {5'd0, 1'b1, (i == 15), 2'd0, 6'(i)});
      chk("pend_overrun", {15'd0, overrun}, {15'd0, (i == 5)});
      if (i == 2) addr = 6'd1;
      if (i == 4) addr = 6'd2;
      cyc();
    end
    check_burst("pend_b2_nobubble", 2'd2);
    chk("pend_end_valid", {15'd0, out_valid}, 16'd0);
    cyc();
    cyc();
    chk("pend_no_b1", {15'd0, out_valid}, 16'd0);

    // Illegal address: sticky flag, no words
    addr = 6'd5;
    cyc();
    chk("bad_set", {15'd0, bad_addr}, 16'd1);
    cyc();
    cyc();
    cyc();
    chk("bad_no_words", {15'd0, out_valid}, 16'd0);
    chk("bad_sticky",   {15'd0, bad_addr},  16'd1);

    // Legal bank 0 burst, then reset with internal idx at 7
    addr = 6'd0;
    cyc();
    cyc();
    for (int i = 0; i < 7; i++) begin
      chk("pre_rst_b0", {7'd0, out_valid, out_data}, {7'd0, 1'b1, 2'd0, 6'(i)});
      if (i < 6) cyc();
    end
    chk("pre_rst_idx",  16'(dut.idx), 16'd7);
    chk("bad_still",    {15'd0, bad_addr}, 16'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst_count", 16'(dut.u_fifo.count), 16'd0);
    chk("mid_rst_data",  {8'd0, out_data}, 16'd0);
    chk("mid_rst_bad",   {15'd0, bad_addr}, 16'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_n1", {15'd0, out_valid}, 16'd0);
    cyc();
    check_burst("post_rst_b0", 2'd0);
    chk("post_rst_end", {15'd0, out_valid}, 16'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
